// File: rtl/datapath_unit_if.sv
// Control-unit <-> datapath signal bundle for datapath_unit.
// DATAPATH_PROGPORT_EN adds the program-load write port signals.
interface datapath_unit_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
) ();
    // Strobes are level-qualified per clock edge; there is no handshake.
    logic              IRload;
    logic              JMPmux;
    logic              PCload;
    logic              Meminst;
    logic              MemWr;
    logic              Aload;
    logic              Sub;
    logic              Halt;
    logic [1:0]        Asel;
    logic [DATA_W-1:0] Input;

    logic [2:0]        IR;
    logic              Aeq0;
    logic              Apos;
    logic [DATA_W-1:0] Aout;
    logic [ADDR_W-1:0] PCout;
    logic              Halted;

`ifdef DATAPATH_PROGPORT_EN
    logic              progWr;
    logic [ADDR_W-1:0] progAddr;
    logic [DATA_W-1:0] progData;
`endif

    modport master (
`ifdef DATAPATH_PROGPORT_EN
        output progWr, progAddr, progData,
`endif
        output IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, Halt, Asel, Input,
        input  IR, Aeq0, Apos, Aout, PCout, Halted
    );

    modport slave (
`ifdef DATAPATH_PROGPORT_EN
        input  progWr, progAddr, progData,
`endif
        input  IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, Halt, Asel, Input,
        output IR, Aeq0, Apos, Aout, PCout, Halted
    );
endinterface

// File: rtl/datapath_unit.sv
// Accumulator datapath: PC, IR, accumulator and a registered-read RAM.
// DATAPATH_PROGPORT_EN adds a program-load write port with top write priority.
module datapath_unit #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
) (
    input  logic           clock,
    input  logic           reset,
    datapath_unit_if.slave dp
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

    generate
        if (DATA_W != 3 + ADDR_W) begin : g_width_check
            $error("datapath_unit: DATA_W must equal 3+ADDR_W");
        end
    endgenerate

    // No reset on the array: program contents survive a reset.
    logic [DATA_W-1:0] mem [DEPTH];

    logic [DATA_W-1:0] ir_reg;
    logic [DATA_W-1:0] a_reg;
    logic [DATA_W-1:0] mem_data;
    logic [ADDR_W-1:0] pc;
    logic              halted;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] a_next;
    logic              mem_we;

    assign mem_addr = dp.Meminst ? ir_reg[ADDR_W-1:0] : pc;
    // Gating on reset keeps a MemWr coincident with reset assertion out of the array.
    assign mem_we   = dp.MemWr && !halted && reset;

    always_comb begin
        a_next = a_reg;
        case (dp.Asel)
            2'b00:   a_next = dp.Sub ? (a_reg - mem_data) : (a_reg + mem_data);
            2'b01:   a_next = dp.Input;
            2'b10:   a_next = mem_data;
            default: a_next = '0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ir_reg   <= '0;
            a_reg    <= '0;
            mem_data <= '0;
            pc       <= '0;
            halted   <= 1'b0;
        end else begin
            mem_data <= mem[mem_addr];
            if (dp.Halt) begin
                halted <= 1'b1;
            end
            if (!halted) begin
                if (dp.IRload) begin
                    ir_reg <= mem_data;
                end
                if (dp.PCload) begin
                    pc <= dp.JMPmux ? ir_reg[ADDR_W-1:0] : pc + PC_ONE;
                end
                if (dp.Aload) begin
                    a_reg <= a_next;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
`ifdef DATAPATH_PROGPORT_EN
        if (dp.progWr) begin
            mem[dp.progAddr] <= dp.progData;
        end else if (mem_we) begin
            mem[mem_addr] <= a_reg;
        end
`else
        if (mem_we) begin
            mem[mem_addr] <= a_reg;
        end
`endif
    end

    assign dp.IR     = ir_reg[DATA_W-1:DATA_W-3];
    assign dp.Aeq0   = (a_reg == '0);
    assign dp.Apos   = !a_reg[DATA_W-1] && (a_reg != '0);
    assign dp.Aout   = a_reg;
    assign dp.PCout  = pc;
    assign dp.Halted = halted;
endmodule

// File: tb/tb_datapath_unit.sv
// Bench for datapath_unit: directed program fragments plus random strobes
// checked against an arithmetic reference model of the datapath.
module tb_datapath_unit;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  datapath_unit_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dp ();

  datapath_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clock (clock),
    .reset (reset),
    .dp    (dp.slave)
  );

  always #5 clock = ~clock;

  // reference model state, plain integers
  int m_mem [DEPTH];
  int m_pc, m_ir, m_a, m_md;
  bit m_halted;
  logic [DATA_W-1:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_pc = 0; m_ir = 0; m_a = 0; m_md = 0; m_halted = 1'b0;
  endfunction

  function automatic void model_edge();
    int addr, rd, n_ir, n_pc, n_a;
    bit prog;
    prog = 1'b0;
`ifdef DATAPATH_PROGPORT_EN
    prog = dp.progWr;
`endif
    if (!reset) begin
`ifdef DATAPATH_PROGPORT_EN
      if (prog) m_mem[int'(dp.progAddr)] = int'(dp.progData);
`endif
      return;
    end
    addr = dp.Meminst ? (m_ir % DEPTH) : m_pc;
    rd   = m_mem[addr];
    if (prog) begin
`ifdef DATAPATH_PROGPORT_EN
      m_mem[int'(dp.progAddr)] = int'(dp.progData);
`endif
    end else if (dp.MemWr && !m_halted) begin
      m_mem[addr] = m_a;
    end
    n_ir = m_ir; n_pc = m_pc; n_a = m_a;
    if (!m_halted) begin
      if (dp.IRload) n_ir = m_md;
      if (dp.PCload) n_pc = dp.JMPmux ? (m_ir % DEPTH) : ((m_pc + 1) % DEPTH);
      if (dp.Aload) begin
        case (int'(dp.Asel))
          0:       n_a = dp.Sub ? ((m_a - m_md + 256) % 256) : ((m_a + m_md) % 256);
          1:       n_a = int'(dp.Input);
          2:       n_a = m_md;
          default: n_a = 0;
        endcase
      end
    end
    m_ir = n_ir; m_pc = n_pc; m_a = n_a; m_md = rd;
    if (dp.Halt) m_halted = 1'b1;
  endfunction

  task automatic compare_all();
    check("IR",     32'(dp.IR),     32'(m_ir / 32));
    check("Aeq0",   32'(dp.Aeq0),   32'(m_a == 0));
    check("Apos",   32'(dp.Apos),   32'(m_a != 0 && m_a < 128));
    check("Aout",   32'(dp.Aout),   32'(m_a));
    check("PCout",  32'(dp.PCout),  32'(m_pc));
    check("Halted", 32'(dp.Halted), 32'(m_halted));
  endtask

  task automatic idle();
    dp.IRload = 0; dp.JMPmux = 0; dp.PCload = 0; dp.Meminst = 0;
    dp.MemWr = 0; dp.Aload = 0; dp.Sub = 0; dp.Halt = 0;
    dp.Asel = 2'b00; dp.Input = '0;
`ifdef DATAPATH_PROGPORT_EN
    dp.progWr = 0; dp.progAddr = '0; dp.progData = '0;
`endif
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    compare_all();
  endtask

  // reset asserted between edges, held across one edge, released between edges
  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    #1;
    compare_all();
    step();
    reset = 1'b1;
  endtask

  task automatic set_pc(input int n);
    do_reset();
    idle();
    dp.PCload = 1;
    repeat (n) step();
    idle();
  endtask

  task automatic write_mem(input int addr, input int data);
    set_pc(addr);
    dp.Aload = 1; dp.Asel = 2'b01; dp.Input = DATA_W'(data);
    step();
    idle();
    dp.MemWr = 1;
    step();
    idle();
  endtask

  initial begin
    idle();
    model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;
    #1;
    compare_all();
    step();
    reset = 1'b1;

    // fill RAM with random words through the accumulator and MemWr
    dp.Aload = 1; dp.Asel = 2'b01; dp.Input = DATA_W'($urandom_range(0, 255));
    step();
    for (int i = 0; i < DEPTH; i++) begin
      dp.MemWr = 1; dp.PCload = 1; dp.Aload = 1; dp.Asel = 2'b01;
      dp.Input = DATA_W'($urandom_range(0, 255));
      step();
    end
    idle();

    // LOAD 3 through start/fetch/decode/load
    write_mem(0, 8'h03);
    write_mem(3, 8'h2A);
    do_reset();
    idle(); step();
    dp.IRload = 1; dp.PCload = 1; step();
    idle(); dp.Meminst = 1; step();
    idle(); dp.Aload = 1; dp.Asel = 2'b10; step();
    idle();
    check("load_ir",   32'(dp.IR),    32'(0));
    check("load_pc",   32'(dp.PCout), 32'(1));
    check("load_aout", 32'(dp.Aout),  32'(8'h2A));
    check("load_apos", 32'(dp.Apos),  32'(1));

    // SUB to zero, then ADD 0x80
    write_mem(7, 8'h05);
    write_mem(8, 8'h80);
    set_pc(7);
    dp.Aload = 1; dp.Asel = 2'b01; dp.Input = 8'h05; step();
    idle(); dp.Aload = 1; dp.Asel = 2'b00; dp.Sub = 1; step();
    idle();
    check("sub_aout", 32'(dp.Aout), 32'(0));
    check("sub_aeq0", 32'(dp.Aeq0), 32'(1));
    check("sub_apos", 32'(dp.Apos), 32'(0));
    dp.PCload = 1; step();
    idle(); step();
    dp.Aload = 1; dp.Asel = 2'b00; step();
    idle();
    check("add_aout", 32'(dp.Aout), 32'(8'h80));
    check("add_apos", 32'(dp.Apos), 32'(0));

    // STORE 7 with read-before-write on the same edge
    write_mem(9, 8'h27);
    set_pc(9);
    step();
    dp.IRload = 1; dp.Aload = 1; dp.Asel = 2'b01; dp.Input = 8'h11; step();
    idle(); dp.Meminst = 1; dp.MemWr = 1; step();
    idle(); dp.Meminst = 1; dp.Aload = 1; dp.Asel = 2'b10; step();
    check("store_old", 32'(dp.Aout), 32'(8'h05));
    idle(); dp.Aload = 1; dp.Asel = 2'b10; step();
    idle();
    check("store_new", 32'(dp.Aout), 32'(8'h11));

    // PC wrap and jump
    set_pc(31);
    dp.PCload = 1; step();
    idle();
    check("pc_wrap", 32'(dp.PCout), 32'(0));
    write_mem(10, 8'hB4);
    set_pc(10);
    step();
    dp.IRload = 1; step();
    idle(); dp.PCload = 1; dp.JMPmux = 1; step();
    idle();
    check("pc_jump", 32'(dp.PCout), 32'(20));

    // halt freezes state until reset
    dp.Aload = 1; dp.Asel = 2'b01; dp.Input = 8'h3C; step();
    idle(); dp.Halt = 1; step();
    idle(); dp.Aload = 1; dp.Asel = 2'b01; dp.Input = 8'h7F; step();
    check("halt_flag", 32'(dp.Halted), 32'(1));
    check("halt_aout", 32'(dp.Aout),   32'(8'h3C));
    idle();
    reset = 1'b0;
    model_reset();
    #1;
    compare_all();
    check("rst_ir",     32'(dp.IR),     32'(0));
    check("rst_aeq0",   32'(dp.Aeq0),   32'(1));
    check("rst_aout",   32'(dp.Aout),   32'(0));
    check("rst_pc",     32'(dp.PCout),  32'(0));
    check("rst_halted", 32'(dp.Halted), 32'(0));
    step();
    reset = 1'b1;

    // reset between edges while a load is pending
    dp.Aload = 1; dp.Asel = 2'b01; dp.Input = 8'h66; step();
    dp.Input = 8'h55;
    reset = 1'b0;
    model_reset();
    #1;
    check("async_rst_aout", 32'(dp.Aout), 32'(0));
    step();
    check("rst_no_load", 32'(dp.Aout), 32'(0));
    reset = 1'b1;
    idle();

    // randomized strobes against the model
    for (int n = 0; n < 500; n++) begin
      dp.IRload  = 1'($urandom_range(0, 1));
      dp.JMPmux  = 1'($urandom_range(0, 1));
      dp.PCload  = 1'($urandom_range(0, 1));
      dp.Meminst = 1'($urandom_range(0, 1));
      dp.MemWr   = ($urandom_range(0, 3) == 0);
      dp.Aload   = 1'($urandom_range(0, 1));
      dp.Sub     = 1'($urandom_range(0, 1));
      dp.Halt    = ($urandom_range(0, 59) == 0);
      dp.Asel    = 2'($urandom_range(0, 3));
      dp.Input   = DATA_W'($urandom_range(0, 255));
`ifdef DATAPATH_PROGPORT_EN
      dp.progWr   = ($urandom_range(0, 5) == 0);
      dp.progAddr = ADDR_W'($urandom_range(0, DEPTH - 1));
      dp.progData = DATA_W'($urandom_range(0, 255));
`endif
      if ($urandom_range(0, 79) == 0) do_reset();
      else step();
    end
    idle();

    // RAM contents survive reset: read every word back through A
    do_reset();
    idle();
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(DATA_W'(m_mem[i]));
    dp.Aload = 1; dp.Asel = 2'b10; dp.PCload = 1;
    step();
    for (int k = 1; k <= DEPTH; k++) begin
      step();
      check("sweep", 32'(dp.Aout), 32'(exp_q.pop_front()));
    end
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/datapath_unit.md
DATAPATH_UNIT -- requirements
Module: datapath_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 8: accumulator, memory word and instruction width.
REQ-002 SHALL have parameter ADDR_W, default 5: PC and memory address width; DATA_W SHALL equal 3+ADDR_W, and elaboration SHALL fail otherwise.
REQ-003 clock  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, Halt  input  1 each  control strobes from the control unit.
REQ-006 Asel  input  2  A source select.
REQ-007 Input  input  DATA_W  manual-entry operand.
REQ-008 IR  output  3  opcode, IRreg[DATA_W-1:DATA_W-3].
REQ-009 Aeq0, Apos  output  1 each  accumulator status.
REQ-010 Aout  output  DATA_W  accumulator value.
REQ-011 PCout  output  ADDR_W  program counter value.
REQ-012 Halted  output  1  registered halt flag.

Function
REQ-013 SHALL hold 2^ADDR_W x DATA_W RAM with synchronous write and registered read: MemData <= Mem[addr] every clock edge, addr = Meminst ? IRreg[ADDR_W-1:0] : PC.
REQ-014 SHALL write Mem[addr] <= A on the edge where MemWr=1; same-edge read SHALL return the old word (read-before-write).
REQ-015 SHALL load IRreg <= MemData when IRload=1.
REQ-016 SHALL update PC when PCload=1: JMPmux=0 -> PC+1 mod 2^ADDR_W (31 wraps to 0); JMPmux=1 -> IRreg[ADDR_W-1:0].
REQ-017 SHALL load A when Aload=1 from Asel: 00 -> A+MemData (Sub=0) or A-MemData (Sub=1), two's complement, truncated to DATA_W, overflow ignored; 01 -> Input; 10 -> MemData; 11 -> 0.
REQ-018 Aeq0 SHALL be combinational (A==0); Apos SHALL be (A[DATA_W-1]==0 && A!=0).
REQ-019 Halted SHALL set on the first edge with Halt=1 and hold until reset; while Halted=1, IRreg, PC, A and Mem SHALL NOT change regardless of strobes.
REQ-020 Simultaneous IRload and PCload SHALL both use pre-edge values (IR gets Mem[old PC], PC increments).
REQ-021 Timing contract: a word addressed during cycle N is usable as MemData in cycle N+1 (start->fetch, decode->load/add/sub).

Reset
REQ-022 reset low SHALL asynchronously clear PC, IRreg, A, MemData and Halted to 0; outputs SHALL read IR=0, Aeq0=1, Apos=0, Aout=0, PCout=0, Halted=0.
REQ-023 Mem contents SHALL NOT be cleared by reset; power-up value 0.
REQ-024 Reset asserted mid-instruction SHALL abandon it; a MemWr on the same edge as reset assertion SHALL NOT be committed.

Configuration
REQ-025 Macro DATAPATH_PROGPORT_EN defined: SHALL add inputs progWr (1), progAddr (ADDR_W), progData (DATA_W); progWr=1 SHALL write Mem[progAddr] <= progData, taking priority over MemWr, also while Halted=1 and while reset is low.
REQ-026 Macro DATAPATH_PROGPORT_EN undefined: these ports SHALL be absent and the only write path SHALL be MemWr.

Verification (DATAPATH_PROGPORT_EN defined)
REQ-027 Load Mem[0]=0x03 (LOAD 3), Mem[3]=0x2A; drive start,fetch,decode,load strobes -> IR=000, PCout=1, Aout=0x2A, Apos=1.
REQ-028 A=0x05, Mem[7]=0x05, SUB from 7 (Sub=1, Asel=00, Aload=1) -> Aout=0x00, Aeq0=1, Apos=0; then ADD 0x80 -> Aout=0x80, Apos=0.
REQ-029 A=0x11, IRreg=0x27 (STORE 7), Meminst=1, MemWr=1 one cycle -> Mem[7]=0x11; next-cycle MemData=0x11.
REQ-030 PC=31, PCload=1, JMPmux=0 -> PC=0; IRreg=0xB4, JMPmux=1, PCload=1 -> PC=20.
REQ-031 Halt=1 one cycle, then Aload=1, Asel=01, Input=0x7F -> Halted=1, Aout unchanged; reset low -> all outputs per REQ-022.
REQ-032 Reset pulsed low between clock edges with Aload=1 -> Aout=0 immediately, no load on next edge while reset low.
